envelope_avg_unit: RTL

Upstream stage of the envelope-controlled filter path. Tracks the amplitude envelope of the incoming signed audio stream with an attack/release peak follower, averages the follower output over fixed blocks of samples, and presents the block average as `env_avg`, the unsigned envelope magnitude consumed by the cutoff-frequency stage. Updates are flagged by a one-cycle `env_valid` pulse; `env_avg` holds between updates.

---
 rtl/envelope_avg_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/envelope_avg_unit.sv
// Envelope follower front end: rectify, attack/release peak follower, then a
// block average of the follower output presented as an unsigned magnitude.
module envelope_avg_unit #(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 8,
    parameter int AVG_LOG2      = 6,
    parameter int FRAC_BITS     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    input  logic                           clear,
    output logic        [SAMPLE_WIDTH-1:0] env_avg,
    output logic                           env_valid
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int EW = SAMPLE_WIDTH + FRAC_BITS;
    localparam int AW = SAMPLE_WIDTH + AVG_LOG2;

    localparam logic signed [W-1:0]    MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic        [W-1:0]    MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [AVG_LOG2-1:0]    CNT_LAST = '1;

    // Absolute value; the one unrepresentable magnitude clips to full scale.
    function automatic logic [W-1:0] rectify(input logic signed [W-1:0] x);
        logic signed [W-1:0] neg;
        neg = -x;
        if (x == MIN_NEG)
            return MAX_POS;
        else if (x < 0)
            return neg;
        else
            return x;
    endfunction

    // One follower step; the minimum step of 1 guarantees exact arrival.
    function automatic logic [EW-1:0] follow(input logic [EW-1:0] cur,
                                             input logic [EW-1:0] tgt);
        logic [EW-1:0] step;
        step = '0;
        if (tgt > cur) begin
            step = (tgt - cur) >> ATTACK_SHIFT;
            if (step == '0)
                step = EW'(1);
            return cur + step;
        end else if (tgt < cur) begin
            step = (cur - tgt) >> RELEASE_SHIFT;
            if (step == '0)
                step = EW'(1);
            return cur - step;
        end
        return cur;
    endfunction

    logic        [W-1:0]        rect_p1;
    logic                       vld_p1;
    logic        [EW-1:0]       env_f_p2;
    logic                       vld_p2;
    logic        [AW-1:0]       acc_p3;
    logic        [AVG_LOG2-1:0] cnt_p3;
    logic        [W-1:0]        env_i;
    logic        [AW-1:0]       avg_sum;

    assign env_i   = env_f_p2[EW-1:FRAC_BITS];
    assign avg_sum = acc_p3 + AW'(env_i);

    // Stage A: rectify
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (clear) begin
            rect_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= sample_valid;
            if (sample_valid)
                rect_p1 <= rectify(sample_in);
        end
    end

    // Stage B: attack/release follower
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_f_p2 <= '0;
            vld_p2   <= 1'b0;
        end else if (clear) begin
            env_f_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                env_f_p2 <= follow(env_f_p2, {rect_p1, {FRAC_BITS{1'b0}}});
        end
    end

    // Stage C: block accumulate and publish the truncated mean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p3    <= '0;
            cnt_p3    <= '0;
            env_avg   <= '0;
            env_valid <= 1'b0;
        end else if (clear) begin
            acc_p3    <= '0;
            cnt_p3    <= '0;
            env_avg   <= '0;
            env_valid <= 1'b0;
        end else begin
            env_valid <= 1'b0;
            if (vld_p2) begin
                if (cnt_p3 == CNT_LAST) begin
                    env_avg   <= avg_sum[AW-1:AVG_LOG2];
                    env_valid <= 1'b1;
                    acc_p3    <= '0;
                    cnt_p3    <= '0;
                end else begin
                    acc_p3 <= avg_sum;
                    cnt_p3 <= cnt_p3 + 1'b1;
                end
            end
        end
    end

endmodule
